tick_strobe_gen: RTL
====================

TICK_STROBE_GEN -- requirements
Module: tick_strobe_gen

Interface
REQ-001 Parameter NB_COUNTER, default 32: prescaler counter width in bits.
REQ-002 Parameter LIMIT_R0, default 50000000: period in clock cycles for rate index 0.
REQ-003 Parameter LIMIT_R1, default 25000000: period in clock cycles for rate index 1.
REQ-004 Parameter LIMIT_R2, default 12500000: period in clock cycles for rate index 2.
REQ-005 Parameter LIMIT_R3, default 6250000: period in clock cycles for rate index 3.
REQ-006 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-007 i_reset  input  1  synchronous, active-high reset.
REQ-008 i_enable  input  1  level; 1 = generate strobes, 0 = stop.
REQ-009 i_sel  input  2  requested rate index (0..3).
REQ-010 o_valid  output  1  one-cycle strobe to downstream LED registers (flash / shift).
REQ-011 o_rate_idx  output  2  rate index currently in effect.
REQ-012 o_running  output  1  1 while the state machine is in COUNT.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE, COUNT.
REQ-014 IDLE: counter held at 0, o_valid 0; when i_enable=1, the block SHALL go to COUNT at the next edge with counter 0 and o_rate_idx loaded from i_sel.
REQ-015 COUNT: the counter SHALL increment by 1 per cycle modulo LIMIT of o_rate_idx, wrapping from LIMIT-1 to 0.
REQ-016 The wrap edge (counter LIMIT-1 -> 0) SHALL set o_valid=1 for exactly one cycle; all other cycles o_valid=0.
REQ-017 Period SHALL be exactly LIMIT cycles; the first strobe is asserted LIMIT cycles after the edge that enters COUNT.
REQ-018 o_valid SHALL be registered (no combinational path from any input).
REQ-019 When i_enable=0 is sampled in COUNT, the block SHALL go to IDLE, clear the counter, and drive o_valid=0 at that edge, even if the counter is at LIMIT-1 (the strobe is suppressed).
REQ-020 o_running SHALL be 1 exactly in the cycles the FSM is in COUNT.
REQ-021 Every LIMIT_Rx SHALL be >= 2 and < 2**NB_COUNTER; counter comparisons SHALL use the full NB_COUNTER width with no truncation.
REQ-022 An i_sel value equal to o_rate_idx SHALL have no effect.

Reset
REQ-023 i_reset=1 SHALL take priority over all other inputs at the sampling edge.
REQ-024 Reset values: FSM IDLE, counter 0, o_valid 0, o_rate_idx 0, o_running 0.
REQ-025 Reset asserted mid-count SHALL discard the partial period; after release, the block SHALL re-enter COUNT per REQ-014 if i_enable=1.

Configuration
REQ-026 Macro TICK_SYNC_RATE_SWITCH_EN defined: in COUNT, i_sel SHALL load into o_rate_idx only at the wrap edge, so the current period always completes at the old rate.
REQ-027 Macro not defined: in COUNT, i_sel != o_rate_idx SHALL load o_rate_idx and clear the counter to 0 at that edge, with no strobe that cycle; the new period starts immediately.

Verification (LIMIT_R0..R3 overridden to 4, 6, 8, 10)
REQ-028 Reset, then i_enable=1 with i_sel=0 -> o_running=1 next edge; o_valid high on every 4th cycle thereafter, each pulse exactly 1 cycle wide.
REQ-029 i_sel=3, enable from IDLE -> o_rate_idx=3; pulses spaced exactly 10 cycles apart.
REQ-030 i_enable dropped in the cycle where counter=3 (rate 0) -> no pulse; o_running=0 and counter=0 at the next edge.
REQ-031 i_reset pulsed for 1 cycle with counter=5 (rate 3) -> all outputs 0; after release, first pulse 10 cycles after COUNT is re-entered.
REQ-032 With TICK_SYNC_RATE_SWITCH_EN: i_sel 0->3 at counter=1 -> next pulse at the 4-cycle boundary; later pulses 10 cycles apart. Without the macro: same stimulus -> counter cleared, next pulse 10 cycles after the change edge.
REQ-033 i_sel toggling to its current value every cycle during COUNT -> pulse spacing unchanged at 4 cycles.

Source files
------------

// File: rtl/tick_strobe_gen.sv
// ============================================================================
// Module      : tick_strobe_gen
// Description : Rate-selectable prescaler producing a one-cycle strobe every
//               LIMIT clocks. Optional macro TICK_SYNC_RATE_SWITCH_EN defers
//               rate changes to the end of the current period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_strobe_gen #(
  parameter int NB_COUNTER = 32,
  parameter int LIMIT_R0   = 50000000,
  parameter int LIMIT_R1   = 25000000,
  parameter int LIMIT_R2   = 12500000,
  parameter int LIMIT_R3   = 6250000
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [1:0] i_sel,
  output logic       o_valid,
  output logic [1:0] o_rate_idx,
  output logic       o_running
);

  // Terminal counts (LIMIT-1) held at full counter width.
  localparam logic [NB_COUNTER-1:0] C_LAST_R0 = NB_COUNTER'(LIMIT_R0 - 1);
  localparam logic [NB_COUNTER-1:0] C_LAST_R1 = NB_COUNTER'(LIMIT_R1 - 1);
  localparam logic [NB_COUNTER-1:0] C_LAST_R2 = NB_COUNTER'(LIMIT_R2 - 1);
  localparam logic [NB_COUNTER-1:0] C_LAST_R3 = NB_COUNTER'(LIMIT_R3 - 1);
  localparam logic [NB_COUNTER-1:0] C_ONE     = NB_COUNTER'(1);
  localparam logic [NB_COUNTER-1:0] C_ZERO    = '0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  state_t                  state_q,   state_d;
  logic [NB_COUNTER-1:0]   cnt_q,     cnt_d;
  logic [1:0]              rate_q,    rate_d;
  logic                    valid_q,   valid_d;
  logic                    running_q, running_d;
  logic [NB_COUNTER-1:0]   w_last;
  logic                    w_wrap;

  always_comb begin
    w_last = C_LAST_R0;
    case (rate_q)
      2'd0:    w_last = C_LAST_R0;
      2'd1:    w_last = C_LAST_R1;
      2'd2:    w_last = C_LAST_R2;
      default: w_last = C_LAST_R3;
    endcase
  end

  assign w_wrap = (cnt_q == w_last);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = C_ZERO;
        if (i_enable) begin
          state_d = ST_COUNT;
          rate_d  = i_sel;
        end
      end
      ST_COUNT: begin
        if (!i_enable) begin
          // Dropping enable wins over a pending wrap: strobe is suppressed.
          state_d = ST_IDLE;
          cnt_d   = C_ZERO;
        end else begin
`ifdef TICK_SYNC_RATE_SWITCH_EN
          if (w_wrap) begin
            cnt_d   = C_ZERO;
            valid_d = 1'b1;
            rate_d  = i_sel;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
`else
          if (i_sel != rate_q) begin
            // Immediate switch: restart the period at the new rate, no strobe.
            rate_d = i_sel;
            cnt_d  = C_ZERO;
          end else if (w_wrap) begin
            cnt_d   = C_ZERO;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = C_ZERO;
      end
    endcase
    running_d = (state_d == ST_COUNT);
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= C_ZERO;
      rate_q    <= 2'd0;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rate_q    <= rate_d;
      valid_q   <= valid_d;
      running_q <= running_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_rate_idx = rate_q;
  assign o_running  = running_q;

endmodule

`default_nettype wire
